// File: rtl/coklu_yazmac_oku_if.sv
`default_nettype none
// ============================================================================
// Module   : coklu_yazmac_oku_if
// Purpose  : Decode-side, writeback, flush and execute-side bus of the
//            register-read stage.
// Revision : 1.0 - initial release
// ============================================================================
interface coklu_yazmac_oku_if #(
    parameter int VERI_BIT     = 32,
    parameter int ADRES_BIT    = 5,
    parameter int ETIKET_BIT   = 4,
    parameter int OKU_PORT     = 3,
    parameter int GERIYAZ_PORT = 2,
    parameter int YUK_BIT      = 64
);
    logic                             giris_gecerli_i;
    logic                             giris_hazir_o;
    logic [OKU_PORT*ADRES_BIT-1:0]    giris_kaynak_adres_i;
    logic [OKU_PORT-1:0]              giris_kaynak_en_i;
    logic [ADRES_BIT-1:0]             giris_hedef_adres_i;
    logic                             giris_hedef_ayir_i;
    logic [ETIKET_BIT-1:0]            giris_etiket_i;
    logic [YUK_BIT-1:0]               giris_yuk_i;
    logic [GERIYAZ_PORT*VERI_BIT-1:0] geriyaz_veri_i;
    logic [GERIYAZ_PORT*ADRES_BIT-1:0] geriyaz_adres_i;
    logic [GERIYAZ_PORT*ETIKET_BIT-1:0] geriyaz_etiket_i;
    logic [GERIYAZ_PORT-1:0]          geriyaz_gecerli_i;
    logic                             bosalt_i;
    logic                             cikis_gecerli_o;
    logic                             cikis_hazir_i;
    logic [OKU_PORT*VERI_BIT-1:0]     cikis_kaynak_veri_o;
    logic [ETIKET_BIT-1:0]            cikis_etiket_o;
    logic [YUK_BIT-1:0]               cikis_yuk_o;
    logic [31:0]                      duraklat_sayaci_o;

    modport slave (
        input  giris_gecerli_i, giris_kaynak_adres_i, giris_kaynak_en_i,
        input  giris_hedef_adres_i, giris_hedef_ayir_i, giris_etiket_i, giris_yuk_i,
        input  geriyaz_veri_i, geriyaz_adres_i, geriyaz_etiket_i, geriyaz_gecerli_i,
        input  bosalt_i, cikis_hazir_i,
        output giris_hazir_o, cikis_gecerli_o, cikis_kaynak_veri_o,
        output cikis_etiket_o, cikis_yuk_o, duraklat_sayaci_o
    );

    modport master (
        output giris_gecerli_i, giris_kaynak_adres_i, giris_kaynak_en_i,
        output giris_hedef_adres_i, giris_hedef_ayir_i, giris_etiket_i, giris_yuk_i,
        output geriyaz_veri_i, geriyaz_adres_i, geriyaz_etiket_i, geriyaz_gecerli_i,
        output bosalt_i, cikis_hazir_i,
        input  giris_hazir_o, cikis_gecerli_o, cikis_kaynak_veri_o,
        input  cikis_etiket_o, cikis_yuk_o, duraklat_sayaci_o
    );
endinterface
`default_nettype wire

// File: rtl/coklu_yazmac_oku.sv
`default_nettype none
// ============================================================================
// Module   : coklu_yazmac_oku
// Purpose  : N-source register-read stage with busy/tag scoreboard, M tagged
//            writeback channels, same-cycle bypass and a stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module coklu_yazmac_oku #(
    parameter int VERI_BIT      = 32,
    parameter int YAZMAC_SAYISI = 32,
    parameter int ADRES_BIT     = 5,
    parameter int ETIKET_BIT    = 4,
    parameter int OKU_PORT      = 3,
    parameter int GERIYAZ_PORT  = 2,
    parameter int YUK_BIT       = 64,
    parameter bit BYPASS_EN     = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    coklu_yazmac_oku_if.slave  bus
);
    logic [VERI_BIT-1:0]          r_veri   [YAZMAC_SAYISI];
    logic [ETIKET_BIT-1:0]        r_etiket [YAZMAC_SAYISI];
    logic [YAZMAC_SAYISI-1:0]     r_mesgul;

    logic                         r_cikis_gecerli;
    logic [OKU_PORT*VERI_BIT-1:0] r_cikis_veri;
    logic [ETIKET_BIT-1:0]        r_cikis_etiket;
    logic [YUK_BIT-1:0]           r_cikis_yuk;
    logic [31:0]                  r_sayac;

    logic [ADRES_BIT-1:0]         w_gy_adr  [GERIYAZ_PORT];
    logic [VERI_BIT-1:0]          w_gy_veri [GERIYAZ_PORT];
    logic [ETIKET_BIT-1:0]        w_gy_etk  [GERIYAZ_PORT];
    logic [GERIYAZ_PORT-1:0]      w_gy_yaz;

    logic [OKU_PORT-1:0]          w_hazir;
    logic [OKU_PORT*VERI_BIT-1:0] w_oku_veri;
    logic                         w_hepsi_hazir;
    logic                         w_bos;
    logic                         w_giris_hazir;
    logic                         w_aktar;

    // A writeback is live only when its tag matches the newest allocation.
    for (genvar k = 0; k < GERIYAZ_PORT; k++) begin : g_gy
        assign w_gy_adr[k]  = bus.geriyaz_adres_i[k*ADRES_BIT +: ADRES_BIT];
        assign w_gy_veri[k] = bus.geriyaz_veri_i[k*VERI_BIT +: VERI_BIT];
        assign w_gy_etk[k]  = bus.geriyaz_etiket_i[k*ETIKET_BIT +: ETIKET_BIT];
        assign w_gy_yaz[k]  = bus.geriyaz_gecerli_i[k] && (w_gy_adr[k] != '0) &&
                              (w_gy_etk[k] == r_etiket[w_gy_adr[k]]);
    end

    for (genvar i = 0; i < OKU_PORT; i++) begin : g_oku
        logic [ADRES_BIT-1:0] w_adr;
        logic                 w_en;
        logic                 w_hit;
        logic [VERI_BIT-1:0]  w_byp;

        assign w_adr = bus.giris_kaynak_adres_i[i*ADRES_BIT +: ADRES_BIT];
        assign w_en  = bus.giris_kaynak_en_i[i];

        // Ascending scan so the highest-numbered matching channel wins.
        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int k = 0; k < GERIYAZ_PORT; k++) begin
                if (w_gy_yaz[k] && (w_gy_adr[k] == w_adr)) begin
                    w_hit = 1'b1;
                    w_byp = w_gy_veri[k];
                end
            end
        end

        assign w_hazir[i] = !w_en || (w_adr == '0) || !r_mesgul[w_adr] ||
                            (BYPASS_EN && w_hit);
        assign w_oku_veri[i*VERI_BIT +: VERI_BIT] =
            (!w_en || (w_adr == '0)) ? '0 :
            (BYPASS_EN && w_hit)     ? w_byp : r_veri[w_adr];
    end

    assign w_hepsi_hazir = &w_hazir;
    assign w_bos         = !r_cikis_gecerli || bus.cikis_hazir_i;
    assign w_giris_hazir = w_bos && w_hepsi_hazir && !bus.bosalt_i;
    assign w_aktar       = bus.giris_gecerli_i && w_giris_hazir;

    // Allocation is applied last so it overrides a same-cycle busy clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < YAZMAC_SAYISI; r++) begin
                r_veri[r]   <= '0;
                r_etiket[r] <= '0;
            end
            r_mesgul <= '0;
        end else begin
            for (int k = 0; k < GERIYAZ_PORT; k++) begin
                if (w_gy_yaz[k]) begin
                    r_veri[w_gy_adr[k]]   <= w_gy_veri[k];
                    r_mesgul[w_gy_adr[k]] <= 1'b0;
                end
            end
            if (bus.bosalt_i) begin
                r_mesgul <= '0;
            end
            if (w_aktar && bus.giris_hedef_ayir_i && (bus.giris_hedef_adres_i != '0)) begin
                r_mesgul[bus.giris_hedef_adres_i] <= 1'b1;
                r_etiket[bus.giris_hedef_adres_i] <= bus.giris_etiket_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cikis_gecerli <= 1'b0;
            r_cikis_veri    <= '0;
            r_cikis_etiket  <= '0;
            r_cikis_yuk     <= '0;
        end else if (w_aktar) begin
            r_cikis_gecerli <= 1'b1;
            r_cikis_veri    <= w_oku_veri;
            r_cikis_etiket  <= bus.giris_etiket_i;
            r_cikis_yuk     <= bus.giris_yuk_i;
        end else if (bus.cikis_hazir_i || bus.bosalt_i) begin
            r_cikis_gecerli <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sayac <= '0;
        end else if (bus.giris_gecerli_i && w_bos && !w_hepsi_hazir &&
                     !bus.bosalt_i && (r_sayac != '1)) begin
            r_sayac <= r_sayac + 32'd1;
        end
    end

    assign bus.giris_hazir_o       = w_giris_hazir;
    assign bus.cikis_gecerli_o     = r_cikis_gecerli;
    assign bus.cikis_kaynak_veri_o = r_cikis_veri;
    assign bus.cikis_etiket_o      = r_cikis_etiket;
    assign bus.cikis_yuk_o         = r_cikis_yuk;
    assign bus.duraklat_sayaci_o   = r_sayac;
endmodule
`default_nettype wire
